hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline stall/flush controller for the 5-stage MIPS core; complements the EX/MEM forwarding logic.
//  Detects hazards that forwarding cannot cover: load-use and reads of a busy multi-cycle mult/div unit.
//  Sequences the PC, IF/ID and ID/EX enables and flushes; squashes wrong-path instructions on a taken branch resolved in EX.
//  Sits in the ID stage; drives PC, IF/ID and ID/EX pipeline registers; counts stall cycles for perf.
// PARAMETERS
//  MD_LATENCY  32  cycles from mult/div entering EX until HI/LO valid (>=2)
//  CNT_W       6   width of mult/div countdown; must hold MD_LATENCY-1
//  PERF_W      32  width of stall-cycle performance counter
// PORTS
//  clk            in   1       core clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  IDEXMemRead    in   1       instruction in EX is a load
//  IDEXRegRt      in   5       load destination register in EX
//  IFIDRegRs      in   5       rs of instruction in ID
//  IFIDRegRt      in   5       rt of instruction in ID
//  IFIDUsesRt     in   1       ID instruction reads rt as source (R-type, beq/bne, sw)
//  IFIDMDRead     in   1       ID instruction is mfhi/mflo
//  IFIDMDOp       in   1       ID instruction is mult/multu/div/divu
//  EXMDStart      in   1       mult/div is in EX this cycle (unit starts)
//  EXBranchTaken  in   1       branch/jump in EX resolved taken
//  PCWrite        out  1       1 = PC updates this cycle
//  IFIDWrite      out  1       1 = IF/ID register loads
//  IFIDFlush      out  1       1 = IF/ID loads a bubble (nop)
//  IDEXFlush      out  1       1 = ID/EX loads a bubble (control bits zero)
//  MDBusy         out  1       mult/div result not yet valid
//  StallCycles    out  PERF_W  saturating count of cycles with PCWrite=0 outside reset
// BEHAVIOUR
//  Reset (rst=1, async): state=S_RUN, md_cnt=0, StallCycles=0; outputs forced PCWrite=0, IFIDWrite=0,
//   IFIDFlush=1, IDEXFlush=1, MDBusy=0. Reset mid-mult/div abandons the operation; no stall follows release.
//  Hazard terms (combinational, same cycle):
//   ld_use = IDEXMemRead & IDEXRegRt!=0 & (IDEXRegRt==IFIDRegRs | (IFIDUsesRt & IDEXRegRt==IFIDRegRt))
//   md_haz = MDBusy & (IFIDMDRead | IFIDMDOp)
//  Output priority, highest first:
//   1 EXBranchTaken: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1; overrides any stall (stalled ID instr is wrong-path)
//   2 ld_use | md_haz: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXFlush=1 (insert one bubble, hold IF/ID)
//   3 else: PCWrite=1, IFIDWrite=1, flushes=0
//  Load-use costs exactly 1 bubble: next cycle the load is in MEM and the forwarding path covers it.
//  Mult/div countdown: EXMDStart -> md_cnt <= MD_LATENCY-1 at the next edge; else md_cnt decrements if nonzero.
//   MDBusy = (md_cnt!=0). EXMDStart while MDBusy reloads md_cnt (cannot occur legally; md_haz blocks it).
//  FSM (2 states, registered):
//   S_RUN  : -> S_MDWAIT when md_haz & ~EXBranchTaken
//   S_MDWAIT: stall held while md_haz; -> S_RUN when md_cnt reaches 0 at the edge (md_cnt==1 & decrementing),
//            or on EXBranchTaken. A load-use during S_MDWAIT stalls identically; state unaffected.
//  The state is informational for perf/debug; outputs depend only on the priority list above.
//  StallCycles: +1 every cycle with PCWrite==0 & ~rst; saturates at all-ones (no wrap).
//  Register 0 never produces a load-use stall; IFIDRegRt is ignored when IFIDUsesRt=0.
// STRUCTURE
//  Shared package (existing ctrl_encode_def.v): FSM encodings `HZ_S_RUN/`HZ_S_MDWAIT, default `MD_LATENCY.
//  One sub-module: md_busy_counter (load, decrement, busy flag; parameters MD_LATENCY, CNT_W).
//  FSM, hazard terms, output priority mux and perf counter remain in hazard_stall_ctrl.
// TESTING
//  lw $8 in EX (IDEXMemRead=1, Rt=8), ID reads rs=8 -> one cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1, then free
//  lw $0 in EX, ID rs=0 -> no stall; lw $9 in EX, ID rt=9 with IFIDUsesRt=0 -> no stall
//  EXMDStart with MD_LATENCY=4, mflo in ID next cycle -> stalled 3 cycles (md_cnt 3,2,1), S_MDWAIT, released when md_cnt=0; StallCycles=3
//  EXBranchTaken during load-use or md stall -> PCWrite=1, IFIDFlush=1, IDEXFlush=1 same cycle; FSM back to S_RUN
//  Assert rst mid-countdown (md_cnt=2) -> MDBusy=0, StallCycles=0, outputs at reset values immediately, no stall after release
//  Force 2^PERF_W stall cycles (PERF_W=4 build) -> StallCycles holds at 4'hF

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl_pkg : shared encodings and defaults for the stall ctrl   |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package hazard_stall_ctrl_pkg;

   typedef enum logic [0:0] {
      S_RUN    = 1'b0,
      S_MDWAIT = 1'b1
   } hzState_t;

   localparam int c_MD_LATENCY_DEFAULT = 32;

   // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
   function automatic logic loadUseHit(
      input logic       memRead,
      input logic [4:0] exRt,
      input logic [4:0] idRs,
      input logic [4:0] idRt,
      input logic       usesRt
   );
      return memRead && (exRt != 5'd0) &&
             ((exRt == idRs) || (usesRt && (exRt == idRt)));
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_busy_counter : countdown tracking when the mult/div HI/LO become valid  |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module md_busy_counter #(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(MD_LATENCY - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= c_LOAD;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_busy = (r_cnt != '0);
   assign o_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl : ID-stage load-use / mult-div stall and branch flush    |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MD_LATENCY = c_MD_LATENCY_DEFAULT,
   parameter int CNT_W      = 6,
   parameter int PERF_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IDEXMemRead,
   input  logic [4:0]        IDEXRegRt,
   input  logic [4:0]        IFIDRegRs,
   input  logic [4:0]        IFIDRegRt,
   input  logic              IFIDUsesRt,
   input  logic              IFIDMDRead,
   input  logic              IFIDMDOp,
   input  logic              EXMDStart,
   input  logic              EXBranchTaken,
   output logic              PCWrite,
   output logic              IFIDWrite,
   output logic              IFIDFlush,
   output logic              IDEXFlush,
   output logic              MDBusy,
   output logic [PERF_W-1:0] StallCycles
);

   hzState_t          r_state;
   logic [PERF_W-1:0] r_stallCycles;
   logic [CNT_W-1:0]  w_mdCnt;
   logic              w_mdBusy;
   logic              w_ldUse;
   logic              w_mdHaz;
   logic              w_mdDone;

   md_busy_counter #(
      .MD_LATENCY (MD_LATENCY),
      .CNT_W      (CNT_W)
   ) u_mdBusyCounter (
      .clk     (clk),
      .rst     (rst),
      .i_start (EXMDStart),
      .o_busy  (w_mdBusy),
      .o_cnt   (w_mdCnt)
   );

   assign w_ldUse  = loadUseHit(IDEXMemRead, IDEXRegRt, IFIDRegRs, IFIDRegRt, IFIDUsesRt);
   assign w_mdHaz  = w_mdBusy && (IFIDMDRead || IFIDMDOp);
   assign w_mdDone = (w_mdCnt == CNT_W'(1)) && !EXMDStart;
   assign MDBusy   = w_mdBusy;

   // A taken branch wins over any stall: the held ID instruction is wrong-path anyway.
   always_comb begin
      PCWrite   = 1'b1;
      IFIDWrite = 1'b1;
      IFIDFlush = 1'b0;
      IDEXFlush = 1'b0;
      if (rst) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         IFIDFlush = 1'b1;
         IDEXFlush = 1'b1;
      end else if (EXBranchTaken) begin
         IFIDFlush = 1'b1;
         IDEXFlush = 1'b1;
      end else if (w_ldUse || w_mdHaz) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         IDEXFlush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RUN;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_mdHaz && !EXBranchTaken) begin
                  r_state <= S_MDWAIT;
               end
            end
            S_MDWAIT: begin
               if (EXBranchTaken || w_mdDone) begin
                  r_state <= S_RUN;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stallCycles <= '0;
      end else if (!PCWrite && (r_stallCycles != '1)) begin
         r_stallCycles <= r_stallCycles + PERF_W'(1);
      end
   end

   assign StallCycles = r_stallCycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_stall_ctrl : directed vectors and corner sequences               |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_hazard_stall_ctrl;
   import hazard_stall_ctrl_pkg::*;

   localparam int c_MD_LAT = 4;
   localparam int c_CNT_W  = 3;
   localparam int c_PERF_W = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                IDEXMemRead, IFIDUsesRt, IFIDMDRead, IFIDMDOp, EXMDStart, EXBranchTaken;
   logic [4:0]          IDEXRegRt, IFIDRegRs, IFIDRegRt;
   logic                PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDBusy;
   logic [c_PERF_W-1:0] StallCycles;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic       memRead;
      logic [4:0] exRt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       usesRt;
      logic       mdRead;
      logic       mdOp;
      logic       branch;
      logic [3:0] expOut;   // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}
   } vec_t;

   vec_t vecs[9];

   hazard_stall_ctrl #(
      .MD_LATENCY (c_MD_LAT),
      .CNT_W      (c_CNT_W),
      .PERF_W     (c_PERF_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .IDEXMemRead   (IDEXMemRead),
      .IDEXRegRt     (IDEXRegRt),
      .IFIDRegRs     (IFIDRegRs),
      .IFIDRegRt     (IFIDRegRt),
      .IFIDUsesRt    (IFIDUsesRt),
      .IFIDMDRead    (IFIDMDRead),
      .IFIDMDOp      (IFIDMDOp),
      .EXMDStart     (EXMDStart),
      .EXBranchTaken (EXBranchTaken),
      .PCWrite       (PCWrite),
      .IFIDWrite     (IFIDWrite),
      .IFIDFlush     (IFIDFlush),
      .IDEXFlush     (IDEXFlush),
      .MDBusy        (MDBusy),
      .StallCycles   (StallCycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOuts(input string name, input logic [3:0] exp);
      check(name, {28'd0, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}, {28'd0, exp});
   endtask

   task automatic clearInputs();
      IDEXMemRead = 0; IDEXRegRt = 0; IFIDRegRs = 0; IFIDRegRt = 0; IFIDUsesRt = 0;
      IFIDMDRead = 0; IFIDMDOp = 0; EXMDStart = 0; EXBranchTaken = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1 time unit after a rising edge with reset released.
   task automatic doReset();
      clearInputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      vecs[0] = '{"ld_rs",        1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, 4'b0001};
      vecs[1] = '{"ld_r0",        1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 4'b1100};
      vecs[2] = '{"ld_rt_unused", 1, 5'd9, 5'd1, 5'd9, 0, 0, 0, 0, 4'b1100};
      vecs[3] = '{"ld_rt_used",   1, 5'd9, 5'd1, 5'd9, 1, 0, 0, 0, 4'b0001};
      vecs[4] = '{"no_load",      0, 5'd8, 5'd8, 5'd8, 1, 0, 0, 0, 4'b1100};
      vecs[5] = '{"ld_branch",    1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 1, 4'b1111};
      vecs[6] = '{"mflo_idle",    0, 5'd0, 5'd2, 5'd3, 0, 1, 1, 0, 4'b1100};
      vecs[7] = '{"branch_only",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 4'b1111};
      vecs[8] = '{"ld_nomatch",   1, 5'd5, 5'd3, 5'd7, 1, 0, 0, 0, 4'b1100};

      clearInputs();
      #1 rst = 1'b1;
      #2;
      checkOuts("reset_outs", 4'b0011);
      check("reset_mdbusy", {31'd0, MDBusy}, 32'd0);
      check("reset_stall", {28'd0, StallCycles}, 32'd0);
      step();
      step();
      rst = 1'b0;

      // Single-cycle combinational vectors, one per clock.
      for (int i = 0; i < 9; i++) begin
         IDEXMemRead   = vecs[i].memRead;
         IDEXRegRt     = vecs[i].exRt;
         IFIDRegRs     = vecs[i].rs;
         IFIDRegRt     = vecs[i].rt;
         IFIDUsesRt    = vecs[i].usesRt;
         IFIDMDRead    = vecs[i].mdRead;
         IFIDMDOp      = vecs[i].mdOp;
         EXBranchTaken = vecs[i].branch;
         #3;
         checkOuts(vecs[i].name, vecs[i].expOut);
         step();
      end
      clearInputs();
      #3;
      check("vec_stall_count", {28'd0, StallCycles}, 32'd2);

      // mult in EX, mflo follows: three stall cycles while md_cnt runs 3,2,1.
      doReset();
      EXMDStart = 1;
      #3;
      checkOuts("md_start_free", 4'b1100);
      step();
      EXMDStart  = 0;
      IFIDMDRead = 1;
      for (int k = 0; k < 3; k++) begin
         #3;
         checkOuts($sformatf("md_stall%0d", k), 4'b0001);
         check($sformatf("md_busy%0d", k), {31'd0, MDBusy}, 32'd1);
         if (k > 0) check($sformatf("md_state%0d", k), {31'd0, dut.r_state}, {31'd0, S_MDWAIT});
         step();
      end
      #3;
      checkOuts("md_release", 4'b1100);
      check("md_busy_clear", {31'd0, MDBusy}, 32'd0);
      check("md_state_run", {31'd0, dut.r_state}, {31'd0, S_RUN});
      check("md_stall_count", {28'd0, StallCycles}, 32'd3);

      // Branch taken while stalled on mult/div.
      doReset();
      EXMDStart = 1;
      step();
      EXMDStart  = 0;
      IFIDMDRead = 1;
      #3;
      checkOuts("br_md_stall", 4'b0001);
      step();
      EXBranchTaken = 1;
      #3;
      checkOuts("br_md_flush", 4'b1111);
      check("br_md_wait", {31'd0, dut.r_state}, {31'd0, S_MDWAIT});
      step();
      clearInputs();
      #3;
      check("br_md_run", {31'd0, dut.r_state}, {31'd0, S_RUN});

      // Asynchronous reset in the middle of a countdown (md_cnt=2).
      doReset();
      EXMDStart = 1;
      step();
      EXMDStart  = 0;
      IFIDMDRead = 1;
      step();
      #1 rst = 1'b1;
      #1;
      checkOuts("rst_mid_outs", 4'b0011);
      check("rst_mid_busy", {31'd0, MDBusy}, 32'd0);
      check("rst_mid_stall", {28'd0, StallCycles}, 32'd0);
      rst = 1'b0;
      #1;
      checkOuts("rst_rel_free", 4'b1100);
      step();
      #3;
      checkOuts("rst_rel_free2", 4'b1100);
      check("rst_rel_count", {28'd0, StallCycles}, 32'd0);

      // Saturation of the 4-bit perf counter.
      doReset();
      IDEXMemRead = 1;
      IDEXRegRt   = 5'd4;
      IFIDRegRs   = 5'd4;
      repeat (14) step();
      #3;
      check("sat_14", {28'd0, StallCycles}, 32'd14);
      repeat (4) step();
      #3;
      check("sat_hold", {28'd0, StallCycles}, 32'd15);
      clearInputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
